// File: rtl/hs_sync_fifo_pkg.sv
// Shared defaults and helpers for the handshake FIFO slice.
// Imported by the interface, the RAM and the FIFO top.
package hs_sync_fifo_pkg;

  localparam int HS_L_DEFAULT          = 8;
  localparam int HS_FIFO_DEPTH_DEFAULT = 4;

  function automatic int hs_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_sync_fifo_if.sv
// Valid/ready bundle around hs_sync_fifo: the _f side is upstream, the _b side is downstream.
// It also carries the occupancy count.
interface hs_sync_fifo_if
  import hs_sync_fifo_pkg::*;
#(
  parameter int L     = HS_L_DEFAULT,
  parameter int DEPTH = HS_FIFO_DEPTH_DEFAULT
);
  localparam int AW = hs_clog2(DEPTH);

  logic          valid_f;
  logic [L-1:0]  data_f;
  logic          ready_f;
  logic          valid_b;
  logic [L-1:0]  data_b;
  logic          ready_b;
  logic [AW:0]   count;

  modport master (
    output valid_f, data_f, ready_b,
    input  ready_f, valid_b, data_b, count
  );

  modport slave (
    input  valid_f, data_f, ready_b,
    output ready_f, valid_b, data_b, count
  );

endinterface

// File: rtl/hs_fifo_ram.sv
// DEPTH x L register array for the FIFO.
// It has one synchronous write port and one combinational read port. Contents are not reset.
module hs_fifo_ram
  import hs_sync_fifo_pkg::*;
#(
  parameter int L     = HS_L_DEFAULT,
  parameter int DEPTH = HS_FIFO_DEPTH_DEFAULT,
  parameter int AW    = hs_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [L-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [L-1:0]  rdata_o
);

  logic [L-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_sync_fifo.sv
// First-word-fall-through valid/ready FIFO placed between the backward skid buffer and the slave.
// Pointers carry a wrap bit so that full and empty can be told apart without a separate flag.
module hs_sync_fifo
  import hs_sync_fifo_pkg::*;
#(
  parameter int L     = HS_L_DEFAULT,
  parameter int DEPTH = HS_FIFO_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  hs_sync_fifo_if.slave fifo_if
);

  localparam int          AW      = hs_clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q,  count_d;
  logic        empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // ready_f depends only on registered state and rst, never on ready_b
  assign fifo_if.ready_f = ~full & ~rst;
  assign fifo_if.valid_b = ~empty;
  assign fifo_if.count   = count_q;

  assign push = fifo_if.valid_f & fifo_if.ready_f;
  assign pop  = fifo_if.valid_b & fifo_if.ready_b;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + PTR_ONE;
    else if (pop && !push) count_d = count_q - PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  hs_fifo_ram #(
    .L     (L),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (fifo_if.data_f),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (fifo_if.data_b)
  );

endmodule

// File: tb/tb_hs_sync_fifo.sv
// Directed bench for hs_sync_fifo (L=8, DEPTH=4).
// It covers reset, fill, drain, streaming with wrap, full-with-pop and a mid-operation reset.
module tb_hs_sync_fifo;
  import hs_sync_fifo_pkg::*;

  localparam int L     = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  hs_sync_fifo_if #(.L(L), .DEPTH(DEPTH)) fifo_if ();

  hs_sync_fifo #(.L(L), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .fifo_if (fifo_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fill_v [4];
  logic [7:0] base;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fill_v[0] = 8'h11; fill_v[1] = 8'h22; fill_v[2] = 8'h33; fill_v[3] = 8'h44;

    // reset held two cycles with valid_f asserted
    rst = 1'b1;
    fifo_if.valid_f = 1'b1;
    fifo_if.data_f  = 8'hEE;
    fifo_if.ready_b = 1'b0;
    #1;
    chk("rst_ready_f_pre", 32'(fifo_if.ready_f), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ready_f", 32'(fifo_if.ready_f), 32'd0);
      chk("rst_valid_b", 32'(fifo_if.valid_b), 32'd0);
      chk("rst_count",   32'(fifo_if.count),   32'd0);
    end
    fifo_if.valid_f = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready_f", 32'(fifo_if.ready_f), 32'd1);

    // fill to full with the downstream stalled
    for (int i = 0; i < 4; i++) begin
      fifo_if.valid_f = 1'b1;
      fifo_if.data_f  = fill_v[i];
      #1;
      chk("fill_ready_f", 32'(fifo_if.ready_f), 32'd1);
      tick();
      chk("fill_count",  32'(fifo_if.count),   32'(i + 1));
      chk("fill_valid_b", 32'(fifo_if.valid_b), 32'd1);
      chk("fill_head",   32'(fifo_if.data_b),  32'h11);
    end
    chk("full_ready_f", 32'(fifo_if.ready_f), 32'd0);
    fifo_if.data_f = 8'h55;
    tick();
    chk("full_hold_count", 32'(fifo_if.count),   32'd4);
    chk("full_hold_ready", 32'(fifo_if.ready_f), 32'd0);

    // drain with upstream idle
    fifo_if.valid_f = 1'b0;
    fifo_if.ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid_b", 32'(fifo_if.valid_b), 32'd1);
      chk("drain_data",    32'(fifo_if.data_b),  32'(fill_v[i]));
      tick();
      chk("drain_count",   32'(fifo_if.count),   32'(3 - i));
    end
    chk("drain_empty", 32'(fifo_if.valid_b), 32'd0);

    // the held 0x55 beat goes in once ready_f is back
    fifo_if.ready_b = 1'b0;
    fifo_if.valid_f = 1'b1;
    fifo_if.data_f  = 8'h55;
    #1;
    chk("p55_ready_f", 32'(fifo_if.ready_f), 32'd1);
    tick();
    fifo_if.valid_f = 1'b0;
    chk("p55_count", 32'(fifo_if.count),  32'd1);
    chk("p55_data",  32'(fifo_if.data_b), 32'h55);
    fifo_if.ready_b = 1'b1;
    tick();
    chk("p55_pop_count", 32'(fifo_if.count),   32'd0);
    chk("p55_pop_valid", 32'(fifo_if.valid_b), 32'd0);

    // continuous streaming; data lags by one beat and pointers wrap several times
    base = 8'h80;
    fifo_if.valid_f = 1'b1;
    fifo_if.ready_b = 1'b1;
    for (int k = 0; k < 20; k++) begin
      fifo_if.data_f = base + 8'(k);
      #1;
      if (k > 0) begin
        chk("stream_data",  32'(fifo_if.data_b), 32'(base + 8'(k - 1)));
        chk("stream_count", 32'(fifo_if.count),  32'd1);
      end
      tick();
    end
    fifo_if.valid_f = 1'b0;
    #1;
    chk("stream_last", 32'(fifo_if.data_b), 32'h93);
    tick();
    chk("stream_end_count", 32'(fifo_if.count), 32'd0);

    // full with a simultaneous pop: ready_f only reopens the next cycle
    fifo_if.ready_b = 1'b0;
    fifo_if.valid_f = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fifo_if.data_f = 8'hA0 + 8'(i);
      tick();
    end
    chk("fp_count4", 32'(fifo_if.count), 32'd4);
    fifo_if.data_f  = 8'hC0;
    fifo_if.ready_b = 1'b1;
    #1;
    chk("fp_ready_f_same", 32'(fifo_if.ready_f), 32'd0);
    chk("fp_head",         32'(fifo_if.data_b),  32'hA0);
    tick();
    chk("fp_count3",       32'(fifo_if.count),   32'd3);
    chk("fp_ready_f_next", 32'(fifo_if.ready_f), 32'd1);
    chk("fp_head2",        32'(fifo_if.data_b),  32'hA1);
    tick();
    chk("fp_both_count", 32'(fifo_if.count),  32'd3);
    chk("fp_head3",      32'(fifo_if.data_b), 32'hA2);

    // bring occupancy to 2, then reset mid-operation
    fifo_if.valid_f = 1'b0;
    tick();
    fifo_if.ready_b = 1'b0;
    chk("mr_count2", 32'(fifo_if.count),  32'd2);
    chk("mr_head",   32'(fifo_if.data_b), 32'hA3);
    rst = 1'b1;
    fifo_if.ready_b = 1'b1;
    #1;
    chk("mr_ready_f_rst", 32'(fifo_if.ready_f), 32'd0);
    tick();
    rst = 1'b0;
    fifo_if.ready_b = 1'b0;
    #1;
    chk("mr_count0", 32'(fifo_if.count),   32'd0);
    chk("mr_valid0", 32'(fifo_if.valid_b), 32'd0);
    chk("mr_ready1", 32'(fifo_if.ready_f), 32'd1);
    fifo_if.valid_f = 1'b1;
    fifo_if.data_f  = 8'hA5;
    tick();
    fifo_if.data_f  = 8'h5A;
    tick();
    fifo_if.valid_f = 1'b0;
    chk("mr_count_after", 32'(fifo_if.count),  32'd2);
    chk("mr_first",       32'(fifo_if.data_b), 32'hA5);
    fifo_if.ready_b = 1'b1;
    tick();
    chk("mr_second", 32'(fifo_if.data_b), 32'h5A);
    tick();
    chk("mr_final_empty", 32'(fifo_if.valid_b), 32'd0);
    fifo_if.ready_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
